// File: rtl/sramx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sramx_arbiter_if                                                         |
// | Upstream channel bundle plus downstream SRAM-like port of the arbiter.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface sramx_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH*DATA_W/8-1:0] ch_wstrb;
    logic [NUM_CH*ADDR_W-1:0]   ch_addr;
    logic [NUM_CH*DATA_W-1:0]   ch_wdata;
    logic [NUM_CH-1:0]          ch_addr_ok;
    logic [NUM_CH-1:0]          ch_data_ok;
    logic [DATA_W-1:0]          ch_rdata;
    logic                       mem_req;
    logic [DATA_W/8-1:0]        mem_wstrb;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       mem_addr_ok;
    logic                       mem_data_ok;
    logic [DATA_W-1:0]          mem_rdata;
    logic                       err_spurious;

    // slave is the arbiter's view; master is the surrounding system
    modport slave (
        input  ch_req, ch_wstrb, ch_addr, ch_wdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output mem_req, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output err_spurious
    );

    modport master (
        output ch_req, ch_wstrb, ch_addr, ch_wdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  mem_req, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  err_spurious
    );
endinterface
`default_nettype wire

// File: rtl/sramx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sramx_arbiter                                                            |
// | Round-robin N:1 SRAM-like arbiter with grant lock, kseg0/1 mapping and   |
// | in-order response routing.                                              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sramx_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUT   = 4,
    parameter int TRANSLATE = 1
) (
    input  wire logic      clk,
    input  wire logic      resetn,
    sramx_arbiter_if.slave bus
);
    localparam int c_ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_PTR_W  = $clog2(MAX_OUT);
    localparam int c_CNT_W  = $clog2(MAX_OUT) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(MAX_OUT);
    localparam logic [c_ID_W-1:0]  c_LAST_CH = c_ID_W'(NUM_CH - 1);

    logic                r_locked;
    logic [c_ID_W-1:0]   r_lock_id;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_fifo [MAX_OUT];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_err;

    logic [c_ID_W-1:0]   w_cand;
    logic [c_ID_W-1:0]   w_sel;
    logic [c_ID_W-1:0]   w_head;
    logic                w_sel_req;
    logic                w_full;
    logic                w_mem_req;
    logic                w_push;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_vaddr;
    logic [ADDR_W-1:0]   w_paddr;
    logic [c_STRB_W-1:0] w_wstrb;
    logic [DATA_W-1:0]   w_wdata;

    // Lowest requester at or above rr_ptr wins, else lowest requester overall
    always_comb begin : p_cand
        w_cand = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_req[i]) begin
                w_cand = c_ID_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_req[i] && (c_ID_W'(i) >= r_rr_ptr)) begin
                w_cand = c_ID_W'(i);
            end
        end
    end

    assign w_sel = r_locked ? r_lock_id : w_cand;

    always_comb begin : p_mux
        w_sel_req = 1'b0;
        w_vaddr   = '0;
        w_wstrb   = '0;
        w_wdata   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c_ID_W'(i) == w_sel) begin
                w_sel_req = bus.ch_req[i];
                w_vaddr   = bus.ch_addr[i*ADDR_W +: ADDR_W];
                w_wstrb   = bus.ch_wstrb[i*c_STRB_W +: c_STRB_W];
                w_wdata   = bus.ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        if (TRANSLATE != 0) begin : g_xlate
            // kseg0 (100) and kseg1 (101) share top bits 2'b10
            always_comb begin
                w_paddr = w_vaddr;
                if (w_vaddr[ADDR_W-1 -: 2] == 2'b10) begin
                    w_paddr[ADDR_W-1 -: 3] = 3'b000;
                end
            end
        end else begin : g_pass
            assign w_paddr = w_vaddr;
        end
    endgenerate

    assign w_full    = (r_count == c_FULL);
    assign w_mem_req = w_sel_req && !w_full;
    assign w_push    = w_mem_req && bus.mem_addr_ok;
    assign w_pop     = bus.mem_data_ok && (r_count != '0);
    assign w_head    = r_fifo[r_rd_ptr];

    always_comb begin : p_onehot
        bus.ch_addr_ok = '0;
        bus.ch_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_addr_ok[i] = w_push && (c_ID_W'(i) == w_sel);
            bus.ch_data_ok[i] = w_pop && (c_ID_W'(i) == w_head);
        end
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_addr     = w_paddr;
    assign bus.mem_wstrb    = w_wstrb;
    assign bus.mem_wdata    = w_wdata;
    assign bus.ch_rdata     = bus.mem_rdata;
    assign bus.err_spurious = r_err;

    // A refused request locks; an accepted or withdrawn one releases the lock
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_locked <= w_mem_req && !bus.mem_addr_ok;
            if (w_mem_req) begin
                r_lock_id <= w_sel;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_rr_ptr <= (w_sel == c_LAST_CH) ? '0 : w_sel + c_ID_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (bus.mem_data_ok && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end
endmodule
`default_nettype wire

// File: doc/sramx_arbiter.md
Name: sramx_arbiter

Overview:
- Parametrised successor to the core-side SRAM top glue: NUM_CH SRAM-like request/response channels (ibus, dbus, future uncached/DMA) share one downstream SRAM-like port.
- Round-robin arbitration with grant lock until address handshake.
- Optional MIPS fixed-mapping virtual-to-physical translation on the issued address.
- In-order outstanding-request tracking that routes data_ok/rdata back to the issuing channel.

Parameters:
- NUM_CH, 2, number of upstream channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- MAX_OUT, 4, max outstanding accepted-but-unanswered requests (power of 2, >=2)
- TRANSLATE, 1, 1 = apply kseg0/kseg1 mapping, 0 = address passthrough

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ch_req  in  NUM_CH  per-channel request valid
- ch_wstrb  in  NUM_CH*DATA_W/8  byte write strobes; all-zero = read
- ch_addr  in  NUM_CH*ADDR_W  virtual address
- ch_wdata  in  NUM_CH*DATA_W  write data
- ch_addr_ok  out  NUM_CH  one-hot; request accepted this cycle
- ch_data_ok  out  NUM_CH  one-hot; response delivered this cycle
- ch_rdata  out  DATA_W  read data, broadcast; valid for channel with ch_data_ok set
- mem_req  out  1  downstream request valid
- mem_wstrb  out  DATA_W/8  strobes of granted channel
- mem_addr  out  ADDR_W  translated address of granted channel
- mem_wdata  out  DATA_W  write data of granted channel
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data
- err_spurious  out  1  sticky: mem_data_ok seen with no outstanding request

Behaviour:
- Reset (resetn=0 at posedge): grant unlocked, rr pointer=0, ID FIFO empty, err_spurious=0. Outputs during and after reset until a request: mem_req=0, ch_addr_ok=0, ch_data_ok=0. ch_rdata = mem_rdata (combinational). Reset aborts in-flight tracking; responses arriving afterwards set err_spurious.
- Arbitration, unlocked:
  - Candidate = first requesting channel searching from rr_ptr upward, wrapping modulo NUM_CH.
  - mem_req = |ch_req & !fifo_full; mem_* fields driven from the candidate, combinationally.
- Handshake:
  - If mem_req && mem_addr_ok: ch_addr_ok[cand]=1 same cycle (zero added latency); push cand ID into FIFO; rr_ptr <= cand+1 mod NUM_CH; stay unlocked.
  - If mem_req && !mem_addr_ok: lock grant to cand at clock edge.
- Locked:
  - mem_* driven from locked channel regardless of other ch_req; channel must hold its request stable (upstream protocol).
  - Unlocks on mem_addr_ok, with push and rr update as above.
  - Locked channel dropping ch_req (protocol violation): unlock and drop, no push.
- FIFO full (MAX_OUT entries): mem_req=0, no ch_addr_ok. A pop in the same cycle does not unblock (push uses registered count).
- Response:
  - On mem_data_ok with FIFO non-empty: ch_data_ok[head]=1, pop, same cycle.
  - Same-cycle push and pop both take effect; count unchanged.
- Spurious response: mem_data_ok with FIFO empty -> no ch_data_ok; err_spurious <= 1, held until reset.
- Translation (TRANSLATE=1, ADDR_W=32):
  - addr[31:29] in {3'b100, 3'b101} (kseg0/kseg1) -> mem_addr = {3'b000, addr[28:0]}.
  - All other addresses pass through unchanged.
  - TRANSLATE=0: always passthrough.
- NUM_CH=1: arbiter degenerates to pass-through; rr_ptr is constant 0.
- Widths: FIFO ID width = max(1, clog2(NUM_CH)); count width = clog2(MAX_OUT)+1.

Test Plan:
- Single read: ch0 req addr 0xBFC00000 wstrb 0, mem_addr_ok same cycle -> mem_addr=0x1FC00000, ch_addr_ok=01. mem_data_ok 2 cycles later with rdata 0x3C1D8000 -> ch_data_ok=01, ch_rdata=0x3C1D8000.
- Round-robin: ch0 and ch1 both request continuously, mem_addr_ok always 1 -> grants alternate 0,1,0,1. kuseg addr 0x00400000 passes through unchanged.
- Lock: ch1 granted, mem_addr_ok low 3 cycles while ch0 also requests -> mem_addr stays ch1's for all 3 cycles; ch_addr_ok=10 in cycle 4; ch0 granted next.
- Ordering/backpressure (MAX_OUT=4): 4 accepted requests IDs 0,1,0,1, no responses -> mem_req=0 on 5th. Four mem_data_ok -> ch_data_ok sequence 01,10,01,10; then mem_req resumes.
- Simultaneous push and pop at count 2 -> count stays 2, both ch_addr_ok and ch_data_ok pulse.
- Spurious/reset: resetn low for 1 cycle with 2 outstanding, then mem_data_ok -> no ch_data_ok, err_spurious=1 persisting until next reset.
